krnl_acc_axi_ctrl_slave_gen: RTL and testbench

Parametrised AXI4-Lite control slave for the accelerator kernel, successor to the fixed-map control slave.
- Holds a configurable number of 32-bit scalar config registers and 64-bit pointer registers.
- Drives the ap_ctrl_chain handshake, with a sticky ap_done, an auto-restart mode and an optional interrupt controller.
- Sits between the host control interface and the kernel top.

---
 rtl/krnl_acc_axi_ctrl_slave_gen.sv | 215 +++++++++++++++++++++
 tb/tb_krnl_acc_axi_ctrl_slave_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/krnl_acc_axi_ctrl_slave_gen.sv
// AXI4-Lite control slave: scalar/pointer config registers plus the ap_ctrl_chain handshake.
// Optional interrupt controller (GIE/IER/ISR) is built only when ACC_CTRL_INTR_EN is defined.
module krnl_acc_axi_ctrl_slave_gen #(
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned NUM_CFG_REGS = 4,
  parameter int unsigned NUM_PTR_REGS = 3
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [C_ADDR_WIDTH-1:0]      AWADDR,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [31:0]                  WDATA,
  input  logic [3:0]                   WSTRB,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [C_ADDR_WIDTH-1:0]      ARADDR,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [31:0]                  RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic                         ap_start,
  input  logic                         ap_done,
  input  logic                         ap_idle,
  input  logic                         ap_ready,
  output logic                         ap_continue,
  output logic                         interrupt,
  output logic [32*NUM_CFG_REGS-1:0]   cfg_regs,
  output logic [64*NUM_PTR_REGS-1:0]   ptr_regs
);

  localparam logic [C_ADDR_WIDTH-1:0] AddrMask = {{(C_ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [C_ADDR_WIDTH-1:0] AddrCtrl = C_ADDR_WIDTH'(32'h000);
  localparam logic [C_ADDR_WIDTH-1:0] AddrGie  = C_ADDR_WIDTH'(32'h004);
  localparam logic [C_ADDR_WIDTH-1:0] AddrIer  = C_ADDR_WIDTH'(32'h008);
  localparam logic [C_ADDR_WIDTH-1:0] AddrIsr  = C_ADDR_WIDTH'(32'h00C);

  typedef enum logic [1:0] {WrReset, WrIdle, WrData, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdReset, RdIdle, RdData} rd_state_e;

  wr_state_e                      wr_state;
  rd_state_e                      rd_state;
  logic [C_ADDR_WIDTH-1:0]        awaddr_q;
  logic [31:0]                    rdata_q;
  logic [NUM_CFG_REGS-1:0][31:0]  cfg_q;
  logic [NUM_PTR_REGS-1:0][63:0]  ptr_q;
  logic start_q, done_q, idle_q, ready_q, cont_q, auto_restart_q;
  logic gie_rd;
  logic [1:0] ier_rd, isr_rd;

  logic                    ar_hs, wr_en, ctrl_wr, ctrl_rd;
  logic [C_ADDR_WIDTH-1:0] waddr, raddr;
  logic [31:0]             rd_val;

  function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] data,
                                              logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) old[8*b +: 8] = data[8*b +: 8];
    end
    return old;
  endfunction

  assign AWREADY = (wr_state == WrIdle);
  assign WREADY  = (wr_state == WrData);
  assign BVALID  = (wr_state == WrResp);
  assign BRESP   = 2'b00;
  assign ARREADY = (rd_state == RdIdle);
  assign RVALID  = (rd_state == RdData);
  assign RRESP   = 2'b00;
  assign RDATA   = rdata_q;

  assign ar_hs   = ARVALID & ARREADY;
  assign wr_en   = WVALID & WREADY;
  assign waddr   = awaddr_q & AddrMask;
  assign raddr   = ARADDR & AddrMask;
  assign ctrl_wr = wr_en && (waddr == AddrCtrl);
  assign ctrl_rd = ar_hs && (raddr == AddrCtrl);

  assign ap_start    = start_q;
  assign ap_continue = cont_q;
  assign cfg_regs    = cfg_q;
  assign ptr_regs    = ptr_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state <= WrReset;
      awaddr_q <= '0;
    end else begin
      case (wr_state)
        WrReset: wr_state <= WrIdle;
        WrIdle:  if (AWVALID) begin
                   awaddr_q <= AWADDR;
                   wr_state <= WrData;
                 end
        WrData:  if (WVALID) wr_state <= WrResp;
        WrResp:  if (BREADY) wr_state <= WrIdle;
        default: wr_state <= WrReset;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    if (raddr == AddrCtrl) begin
      rd_val = {24'b0, auto_restart_q, 2'b00, cont_q, ready_q, idle_q, done_q, start_q};
    end
    if (raddr == AddrGie) rd_val = {31'b0, gie_rd};
    if (raddr == AddrIer) rd_val = {30'b0, ier_rd};
    if (raddr == AddrIsr) rd_val = {30'b0, isr_rd};
    for (int i = 0; i < int'(NUM_CFG_REGS); i++) begin
      if (raddr == C_ADDR_WIDTH'(16 + 4 * i)) rd_val = cfg_q[i];
    end
    for (int j = 0; j < int'(NUM_PTR_REGS); j++) begin
      if (raddr == C_ADDR_WIDTH'(64 + 8 * j)) rd_val = ptr_q[j][31:0];
      if (raddr == C_ADDR_WIDTH'(68 + 8 * j)) rd_val = ptr_q[j][63:32];
    end
  end

  // RDATA is captured at ar_hs so it stays stable however long RREADY is held off.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_state <= RdReset;
      rdata_q  <= '0;
    end else begin
      case (rd_state)
        RdReset: rd_state <= RdIdle;
        RdIdle:  if (ARVALID) begin
                   rdata_q  <= rd_val;
                   rd_state <= RdData;
                 end
        RdData:  if (RREADY) rd_state <= RdIdle;
        default: rd_state <= RdReset;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cfg_q          <= '0;
      ptr_q          <= '0;
      start_q        <= 1'b0;
      done_q         <= 1'b0;
      idle_q         <= 1'b0;
      ready_q        <= 1'b0;
      cont_q         <= 1'b0;
      auto_restart_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CFG_REGS); i++) begin
        if (wr_en && (waddr == C_ADDR_WIDTH'(16 + 4 * i))) begin
          cfg_q[i] <= merge_bytes(cfg_q[i], WDATA, WSTRB);
        end
      end
      for (int j = 0; j < int'(NUM_PTR_REGS); j++) begin
        if (wr_en && (waddr == C_ADDR_WIDTH'(64 + 8 * j))) begin
          ptr_q[j][31:0] <= merge_bytes(ptr_q[j][31:0], WDATA, WSTRB);
        end
        if (wr_en && (waddr == C_ADDR_WIDTH'(68 + 8 * j))) begin
          ptr_q[j][63:32] <= merge_bytes(ptr_q[j][63:32], WDATA, WSTRB);
        end
      end
      idle_q  <= ap_idle;
      ready_q <= ap_ready;
      cont_q  <= ctrl_wr & WSTRB[0] & WDATA[4];
      if (ctrl_wr && WSTRB[0]) auto_restart_q <= WDATA[7];
      if (ctrl_wr && WSTRB[0] && WDATA[0]) begin
        start_q <= 1'b1;
      end else if (ap_ready && !auto_restart_q) begin
        start_q <= 1'b0;
      end
      // A new ap_done beats the clear-on-read so no completion is lost.
      if (ap_done) begin
        done_q <= 1'b1;
      end else if (ctrl_rd) begin
        done_q <= 1'b0;
      end
    end
  end

`ifdef ACC_CTRL_INTR_EN
  logic       gie_q, irq_q;
  logic [1:0] ier_q, isr_q, isr_toggle;

  assign isr_toggle = (wr_en && (waddr == AddrIsr) && WSTRB[0]) ? WDATA[1:0] : 2'b00;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      gie_q <= 1'b0;
      ier_q <= 2'b00;
      isr_q <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && (waddr == AddrGie) && WSTRB[0]) gie_q <= WDATA[0];
      if (wr_en && (waddr == AddrIer) && WSTRB[0]) ier_q <= WDATA[1:0];
      isr_q <= (isr_q ^ isr_toggle) | ({ap_ready, ap_done} & ier_q);
      irq_q <= gie_q & (|isr_q);
    end
  end

  assign gie_rd    = gie_q;
  assign ier_rd    = ier_q;
  assign isr_rd    = isr_q;
  assign interrupt = irq_q;
`else
  assign gie_rd    = 1'b0;
  assign ier_rd    = 2'b00;
  assign isr_rd    = 2'b00;
  assign interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_krnl_acc_axi_ctrl_slave_gen.sv
// Bench for krnl_acc_axi_ctrl_slave_gen: directed handshake cases plus random register traffic
// scored against an address-map model.
module tb_krnl_acc_axi_ctrl_slave_gen;
  localparam int unsigned AW   = 12;
  localparam int unsigned NCFG = 4;
  localparam int unsigned NPTR = 3;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [AW-1:0]   AWADDR = '0;
  logic            AWVALID = 1'b0;
  logic            AWREADY;
  logic [31:0]     WDATA = '0;
  logic [3:0]      WSTRB = '0;
  logic            WVALID = 1'b0;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY = 1'b0;
  logic [AW-1:0]   ARADDR = '0;
  logic            ARVALID = 1'b0;
  logic            ARREADY;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY = 1'b0;
  logic            ap_start;
  logic            ap_done = 1'b0;
  logic            ap_idle = 1'b0;
  logic            ap_ready = 1'b0;
  logic            ap_continue;
  logic            interrupt;
  logic [32*NCFG-1:0] cfg_regs;
  logic [64*NPTR-1:0] ptr_regs;

  always #5 ACLK = ~ACLK;

  krnl_acc_axi_ctrl_slave_gen #(
    .C_ADDR_WIDTH(AW),
    .NUM_CFG_REGS(NCFG),
    .NUM_PTR_REGS(NPTR)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .ap_continue(ap_continue), .interrupt(interrupt),
    .cfg_regs(cfg_regs), .ptr_regs(ptr_regs)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cfg_m [NCFG];
  logic [63:0] ptr_m [NPTR];
  logic        cont_seen, cont_after;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] data, logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) cfg_m[i] = '0;
    for (int j = 0; j < NPTR; j++) ptr_m[j] = '0;
  endtask

  // Word address a: cfg block at 0x10, pointer block (lo/hi pairs) at 0x40.
  task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] d,
                             input logic [3:0] s);
    int a = int'(addr) / 4 * 4;
    if (a >= 16 && a < 16 + 4 * NCFG) begin
      cfg_m[(a - 16) / 4] = merge(cfg_m[(a - 16) / 4], d, s);
    end else if (a >= 64 && a < 64 + 8 * NPTR) begin
      if (a % 8 == 0) ptr_m[(a - 64) / 8][31:0] = merge(ptr_m[(a - 64) / 8][31:0], d, s);
      else ptr_m[(a - 64) / 8][63:32] = merge(ptr_m[(a - 64) / 8][63:32], d, s);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
    int a = int'(addr) / 4 * 4;
    if (a >= 16 && a < 16 + 4 * NCFG) return cfg_m[(a - 16) / 4];
    if (a >= 64 && a < 64 + 8 * NPTR) begin
      if (a % 8 == 0) return ptr_m[(a - 64) / 8][31:0];
      return ptr_m[(a - 64) / 8][63:32];
    end
    return 32'h0;
  endfunction

  task automatic check_ports(input string tag);
    for (int i = 0; i < NCFG; i++) check({tag, "_cfg"}, cfg_regs[32*i +: 32], cfg_m[i]);
    for (int j = 0; j < NPTR; j++) check({tag, "_ptr"}, ptr_regs[64*j +: 64], ptr_m[j]);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    AWADDR = addr;
    AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 20) begin tick(); n++; end
    check("awready", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    WDATA = d;
    WSTRB = s;
    WVALID = 1'b1;
    n = 0;
    while (!WREADY && n < 20) begin tick(); n++; end
    check("wready", WREADY, 1);
    tick();
    WVALID = 1'b0;
    cont_seen = ap_continue;
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 20) begin tick(); n++; end
    check("bvalid", BVALID, 1);
    check("bresp", BRESP, 0);
    tick();
    BREADY = 1'b0;
    cont_after = ap_continue;
    check("bvalid_drop", BVALID, 0);
    model_write(addr, d, s);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic done_at_hs,
                          output logic [31:0] d);
    int n;
    ARADDR = addr;
    ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin tick(); n++; end
    check("arready", ARREADY, 1);
    if (done_at_hs) ap_done = 1'b1;
    tick();
    ARVALID = 1'b0;
    ap_done = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin tick(); n++; end
    check("rvalid", RVALID, 1);
    tick($urandom_range(0, 3));
    d = RDATA;
    check("rresp", RRESP, 0);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rvalid_drop", RVALID, 0);
  endtask

  task automatic pulse_ready();
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
  endtask

  task automatic pulse_done();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick(3);
    check("rst_awready", AWREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_start", ap_start, 0);
    check("rst_continue", ap_continue, 0);
    check("rst_interrupt", interrupt, 0);
    check_ports("rst");
    ARESETn = 1'b1;
    check("post_rst_awready", AWREADY, 0);
    check("post_rst_arready", ARREADY, 0);
    tick();
    check("idle_awready", AWREADY, 1);
    check("idle_arready", ARREADY, 1);

    // Byte-masked scalar write.
    axi_write(12'h010, 32'h1234_5678, 4'b0011);
    axi_read(12'h010, 1'b0, rd);
    check("cfg0_strb_read", rd, 32'h0000_5678);
    check("cfg0_port", cfg_regs[15:0], 16'h5678);

    // Pointer halves, address low bits ignored, unused pointer and unmapped slots.
    axi_write(12'h044, 32'hDEAD_BEEF, 4'hF);
    axi_write(12'h040, 32'h0000_1000, 4'hF);
    check("ptr0_port", ptr_regs[63:0], 64'hDEADBEEF_00001000);
    axi_read(12'h050, 1'b0, rd);
    check("ptr2_lo_unwritten", rd, 32'h0);
    axi_read(12'h047, 1'b0, rd);
    check("ptr0_hi_lowbits", rd, 32'hDEAD_BEEF);
    axi_write(12'h058, 32'hFFFF_FFFF, 4'hF);
    axi_read(12'h058, 1'b0, rd);
    check("unmapped_58", rd, 32'h0);
    check_ports("after_unmapped");

    // ap_start clear on ap_ready, then auto-restart keeps it high.
    axi_write(12'h000, 32'h1, 4'hF);
    check("start_set", ap_start, 1);
    ap_ready = 1'b1;
    check("start_before_ready_edge", ap_start, 1);
    tick();
    ap_ready = 1'b0;
    check("start_cleared", ap_start, 0);
    axi_write(12'h000, 32'h81, 4'hF);
    for (int k = 0; k < 3; k++) begin
      pulse_ready();
      check("start_auto_restart", ap_start, 1);
      tick();
    end
    axi_read(12'h000, 1'b0, rd);
    check("ctrl_auto", rd, 32'h81);
    axi_write(12'h000, 32'h0, 4'hF);
    check("start_after_ar_off", ap_start, 1);
    pulse_ready();
    check("start_cleared_ar_off", ap_start, 0);

    // Continue pulse lasts one cycle.
    axi_write(12'h000, 32'h10, 4'hF);
    check("continue_pulse", cont_seen, 1);
    check("continue_end", cont_after, 0);
    axi_write(12'h000, 32'h10, 4'hE);
    check("continue_no_strb", cont_seen, 0);

    // Idle status is a registered copy.
    ap_idle = 1'b1;
    tick(2);
    axi_read(12'h000, 1'b0, rd);
    check("ctrl_idle", rd, 32'h4);
    ap_idle = 1'b0;
    tick();

    // Sticky done, clear on read, set beats clear.
    pulse_done();
    axi_read(12'h000, 1'b0, rd);
    check("done_first_read", rd[1], 1);
    axi_read(12'h000, 1'b0, rd);
    check("done_cleared", rd[1], 0);
    pulse_done();
    axi_read(12'h000, 1'b1, rd);
    check("done_coinc_first", rd[1], 1);
    axi_read(12'h000, 1'b0, rd);
    check("done_coinc_second", rd[1], 1);
    axi_read(12'h000, 1'b0, rd);
    check("done_coinc_third", rd[1], 0);

`ifdef ACC_CTRL_INTR_EN
    axi_write(12'h004, 32'h1, 4'hF);
    axi_write(12'h008, 32'h1, 4'hF);
    check("irq_idle", interrupt, 0);
    pulse_done();
    tick(2);
    check("irq_raised", interrupt, 1);
    axi_read(12'h00C, 1'b0, rd);
    check("isr_done", rd, 32'h1);
    axi_write(12'h00C, 32'h1, 4'hF);
    tick();
    check("irq_cleared", interrupt, 0);
    axi_read(12'h00C, 1'b0, rd);
    check("isr_cleared", rd, 32'h0);
    pulse_ready();
    tick(2);
    axi_read(12'h00C, 1'b0, rd);
    check("isr_ready_masked", rd, 32'h0);
    check("irq_ready_masked", interrupt, 0);
`else
    axi_write(12'h004, 32'h1, 4'hF);
    axi_write(12'h008, 32'h3, 4'hF);
    pulse_done();
    tick(3);
    check("irq_absent", interrupt, 0);
    axi_read(12'h004, 1'b0, rd);
    check("gie_absent", rd, 32'h0);
    axi_read(12'h008, 1'b0, rd);
    check("ier_absent", rd, 32'h0);
    axi_read(12'h00C, 1'b0, rd);
    check("isr_absent", rd, 32'h0);
`endif

    // Random traffic over the cfg/pointer window and beyond it.
    for (int k = 0; k < 60; k++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) a = AW'(32'h100 + 4 * $urandom_range(0, 63));
      else a = AW'(32'h10 + 4 * $urandom_range(0, 27));
      a = a | AW'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)));
        check_ports("rand_wr");
      end else begin
        axi_read(a, 1'b0, rd);
        check("rand_rd", rd, model_read(a));
      end
    end

    // Reset in the middle of a write aborts it.
    AWADDR = 12'h014;
    AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("abort_in_data", WREADY, 1);
    ARESETn = 1'b0;
    tick(2);
    check("abort_bvalid_rst", BVALID, 0);
    ARESETn = 1'b1;
    model_reset();
    check("abort_awready_low", AWREADY, 0);
    check("abort_bvalid_rel", BVALID, 0);
    tick();
    check("abort_awready_high", AWREADY, 1);
    check("abort_bvalid_after", BVALID, 0);
    check("abort_start", ap_start, 0);
    check_ports("abort");
    axi_read(12'h010, 1'b0, rd);
    check("abort_cfg0", rd, 32'h0);
    axi_read(12'h014, 1'b0, rd);
    check("abort_cfg1", rd, 32'h0);
    axi_read(12'h044, 1'b0, rd);
    check("abort_ptr0_hi", rd, 32'h0);
    axi_read(12'h000, 1'b0, rd);
    check("abort_ctrl", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
